sha2_round_engine: RTL and testbench

Iterative SHA-2 compression engine, parametrised for SHA-256 (32-bit words, 64 rounds) or SHA-512 (64-bit words, 80 rounds). It runs one compression round per accepted message-schedule word, using the Ch, Maj, Σ0 and Σ1 functions at the configured width. After the last round it adds the working state back into the chaining value. It sits between the message-schedule generator (upstream, which supplies W_t+K_t) and the digest/padding controller (downstream, which supplies the chaining value and collects the result).

---
 rtl/sha2_round_engine.sv | 164 ++++++++++++++++
 tb/tb_sha2_round_engine.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha2_round_engine.sv
// Iterative SHA-2 compression engine: one round per accepted W_t+K_t word,
// SHA-256 (WORD_W=32, ROUNDS=64) or SHA-512 (WORD_W=64, ROUNDS=80).
module sha2_round_engine #(
   parameter int WORD_W = 64,
   parameter int ROUNDS = 80
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [8*WORD_W-1:0] h_in,
   input  logic [WORD_W-1:0]   wk_in,
   input  logic                wk_valid,
   output logic                wk_ready,
   output logic                busy,
   output logic                done,
   output logic [8*WORD_W-1:0] h_out
);

   localparam int               CNT_W    = $clog2(ROUNDS);
   localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_FINAL = 2'd2
   } state_t;

   state_t              state_r;
   state_t              state_s;
   logic [CNT_W-1:0]    cnt_r;
   logic [WORD_W-1:0]   work_r   [8];
   logic [WORD_W-1:0]   saved_r  [8];
   logic [WORD_W-1:0]   h_in_w_s [8];
   logic [WORD_W-1:0]   sum_s    [8];
   logic [WORD_W-1:0]   t1_s;
   logic [WORD_W-1:0]   t2_s;
   logic                xfer_s;
   logic                wk_ready_r;
   logic                busy_r;
   logic                done_r;
   logic [8*WORD_W-1:0] h_out_r;

   generate
      if (!((WORD_W == 32 && ROUNDS == 64) || (WORD_W == 64 && ROUNDS == 80))) begin : g_bad_cfg
         $fatal(1, "sha2_round_engine: WORD_W/ROUNDS must be 32/64 or 64/80");
      end
   endgenerate

   function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

   function automatic logic [WORD_W-1:0] big_sigma0(input logic [WORD_W-1:0] x);
      if (WORD_W == 32) return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
      else              return rotr(x, 28) ^ rotr(x, 34) ^ rotr(x, 39);
   endfunction

   function automatic logic [WORD_W-1:0] big_sigma1(input logic [WORD_W-1:0] x);
      if (WORD_W == 32) return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
      else              return rotr(x, 14) ^ rotr(x, 18) ^ rotr(x, 41);
   endfunction

   // H0 sits in the most significant word of the packed chaining value
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_words
         assign h_in_w_s[gi] = h_in[(8-gi)*WORD_W-1 -: WORD_W];
         assign sum_s[gi]    = saved_r[gi] + work_r[gi];
      end
   endgenerate

   assign xfer_s = (state_r == ST_ROUND) && wk_valid;

   // Round function on the current working state a..h = work_r[0..7]
   always_comb begin
      t1_s = work_r[7] + big_sigma1(work_r[4])
           + ((work_r[4] & work_r[5]) ^ (~work_r[4] & work_r[6])) + wk_in;
      t2_s = big_sigma0(work_r[0])
           + ((work_r[0] & work_r[1]) ^ (work_r[0] & work_r[2]) ^ (work_r[1] & work_r[2]));
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_s = ST_ROUND;
            else       state_s = ST_IDLE;
         end
         ST_ROUND: begin
            if (xfer_s && cnt_r == LAST_RND) state_s = ST_FINAL;
            else                             state_s = ST_ROUND;
         end
         ST_FINAL: state_s = ST_IDLE;
         default:  state_s = ST_IDLE;
      endcase
   end

   // State register with status flags registered from the next state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         wk_ready_r <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         wk_ready_r <= (state_s == ST_ROUND);
         busy_r     <= (state_s != ST_IDLE);
      end
   end

   // Working/saved registers, round counter and digest output
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r   <= '0;
         done_r  <= 1'b0;
         h_out_r <= '0;
         for (int i = 0; i < 8; i++) begin
            work_r[i]  <= '0;
            saved_r[i] <= '0;
         end
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  cnt_r <= '0;
                  for (int i = 0; i < 8; i++) begin
                     work_r[i]  <= h_in_w_s[i];
                     saved_r[i] <= h_in_w_s[i];
                  end
               end
            end
            ST_ROUND: begin
               if (wk_valid) begin
                  work_r[7] <= work_r[6];
                  work_r[6] <= work_r[5];
                  work_r[5] <= work_r[4];
                  work_r[4] <= work_r[3] + t1_s;
                  work_r[3] <= work_r[2];
                  work_r[2] <= work_r[1];
                  work_r[1] <= work_r[0];
                  work_r[0] <= t1_s + t2_s;
                  if (cnt_r != LAST_RND) cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            ST_FINAL: begin
               h_out_r <= {sum_s[0], sum_s[1], sum_s[2], sum_s[3],
                           sum_s[4], sum_s[5], sum_s[6], sum_s[7]};
               done_r  <= 1'b1;
            end
            default: begin
               done_r <= 1'b0;
            end
         endcase
      end
   end

   assign wk_ready = wk_ready_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign h_out    = h_out_r;

endmodule

// File: tb/tb_sha2_round_engine.sv
// Scoreboard bench for sha2_round_engine: SHA-256 and SHA-512 instances driven
// from a plain-arithmetic SHA-2 model, with done timing and digest checked by a monitor.
module tb_sha2_round_engine;

   localparam logic [63:0] K512 [80] = '{
      64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
      64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
      64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
      64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
      64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
      64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
      64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
      64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
      64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
      64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
      64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
      64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
      64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
      64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
      64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
      64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
      64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
      64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
      64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
      64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};

   localparam logic [511:0] IV256  = {256'h0,
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19};
   localparam logic [511:0] IV512  =
      512'h6a09e667f3bcc908_bb67ae8584caa73b_3c6ef372fe94f82b_a54ff53a5f1d36f1_510e527fade682d1_9b05688c2b3e6c1f_1f83d9abfb41bd6b_5be0cd19137e2179;
   localparam logic [511:0] ABC256 = {256'h0,
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad};
   localparam logic [511:0] ABC512 =
      512'hddaf35a193617aba_cc417349ae204131_12e6fa4e89a97ea2_0a9eeee64b55d39a_2192992a274fc1a8_36ba3c23a3feebbd_454d4423643ce80e_2a9ac94fa54ca49f;

   typedef struct {
      logic [511:0] dig;
      int           at;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic         s_start, s_valid, s_ready, s_busy, s_done;
   logic [255:0] s_hin, s_hout;
   logic [31:0]  s_wk;
   logic         l_start, l_valid, l_ready, l_busy, l_done;
   logic [511:0] l_hin, l_hout;
   logic [63:0]  l_wk;

   sha2_round_engine #(.WORD_W(32), .ROUNDS(64)) u_sha256 (
      .clk(clk), .reset(reset), .start(s_start), .h_in(s_hin), .wk_in(s_wk),
      .wk_valid(s_valid), .wk_ready(s_ready), .busy(s_busy), .done(s_done), .h_out(s_hout));

   sha2_round_engine #(.WORD_W(64), .ROUNDS(80)) u_sha512 (
      .clk(clk), .reset(reset), .start(l_start), .h_in(l_hin), .wk_in(l_wk),
      .wk_valid(l_valid), .wk_ready(l_ready), .busy(l_busy), .done(l_done), .h_out(l_hout));

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc   = 0;
   exp_t        q256[$];
   exp_t        q512[$];
   logic [63:0] blk_cur [16];
   logic [63:0] wk_cur  [80];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [63:0] wmask(input int w);
      return (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
   endfunction

   function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
      return ((x >> n) | (x << (w - n))) & wmask(w);
   endfunction

   function automatic logic [63:0] bsig(input logic [63:0] x, input int which, input int w);
      if (w == 32) return (which == 0) ? (rotr(x, 2, w) ^ rotr(x, 13, w) ^ rotr(x, 22, w))
                                       : (rotr(x, 6, w) ^ rotr(x, 11, w) ^ rotr(x, 25, w));
      return (which == 0) ? (rotr(x, 28, w) ^ rotr(x, 34, w) ^ rotr(x, 39, w))
                          : (rotr(x, 14, w) ^ rotr(x, 18, w) ^ rotr(x, 41, w));
   endfunction

   function automatic logic [63:0] ssig(input logic [63:0] x, input int which, input int w);
      if (w == 32) return (which == 0) ? (rotr(x, 7, w) ^ rotr(x, 18, w) ^ (x >> 3))
                                       : (rotr(x, 17, w) ^ rotr(x, 19, w) ^ (x >> 10));
      return (which == 0) ? (rotr(x, 1, w) ^ rotr(x, 8, w) ^ (x >> 7))
                          : (rotr(x, 19, w) ^ rotr(x, 61, w) ^ (x >> 6));
   endfunction

   // Expand blk_cur into the W_t+K_t stream the upstream scheduler would supply
   task automatic sched(input int w, input int r);
      logic [63:0] wv [80];
      logic [63:0] m;
      m = wmask(w);
      for (int t = 0; t < r; t++) begin
         if (t < 16) wv[t] = blk_cur[t] & m;
         else wv[t] = (ssig(wv[t-2], 1, w) + wv[t-7] + ssig(wv[t-15], 0, w) + wv[t-16]) & m;
         wk_cur[t] = (wv[t] + ((w == 64) ? K512[t] : (K512[t] >> 32))) & m;
      end
   endtask

   function automatic logic [511:0] compress(input int w, input int r, input logic [511:0] hp);
      logic [63:0]  m, t1, t2;
      logic [63:0]  hv [8];
      logic [63:0]  v  [8];
      logic [511:0] res;
      m = wmask(w);
      for (int i = 0; i < 8; i++) hv[i] = 64'(hp >> ((7 - i) * w)) & m;
      v = hv;
      for (int t = 0; t < r; t++) begin
         t1 = (v[7] + bsig(v[4], 1, w) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + wk_cur[t]) & m;
         t2 = (bsig(v[0], 0, w) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]))) & m;
         for (int j = 7; j > 0; j--) v[j] = v[j-1];
         v[4] = (v[4] + t1) & m;
         v[0] = (t1 + t2) & m;
      end
      res = '0;
      for (int i = 0; i < 8; i++) res = res | (512'((hv[i] + v[i]) & m) << ((7 - i) * w));
      return res;
   endfunction

   task automatic set_abc(input int w);
      for (int i = 0; i < 16; i++) blk_cur[i] = 64'h0;
      blk_cur[0]  = (w == 32) ? 64'h0000_0000_6162_6380 : 64'h6162_6380_0000_0000;
      blk_cur[15] = 64'h18;
   endtask

   task automatic set_rand(input int w);
      for (int i = 0; i < 16; i++) blk_cur[i] = {$urandom(), $urandom()} & wmask(w);
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic drive(input int sel, input logic st, input logic vl, input logic [63:0] wk,
                        input logic [511:0] hp);
      if (sel == 0) begin
         s_start = st; s_valid = vl; s_wk = wk[31:0]; s_hin = hp[255:0];
      end else begin
         l_start = st; l_valid = vl; l_wk = wk; l_hin = hp;
      end
   endtask

   function automatic logic obs_busy(input int sel);
      return (sel == 0) ? s_busy : l_busy;
   endfunction

   function automatic logic obs_ready(input int sel);
      return (sel == 0) ? s_ready : l_ready;
   endfunction

   function automatic logic obs_done(input int sel);
      return (sel == 0) ? s_done : l_done;
   endfunction

   // Run one block starting at a negedge; returns at the negedge of the done cycle
   task automatic run_block(input int sel, input logic [511:0] hp, input bit stall,
                            input bit junk_valid, input int ign_at, input bit use_known,
                            input logic [511:0] known, output logic [511:0] dig);
      int   w, r, st_total, s;
      int   stall_n [80];
      exp_t e;
      w = (sel == 0) ? 32 : 64;
      r = (sel == 0) ? 64 : 80;
      st_total = 0;
      for (int t = 0; t < 80; t++) stall_n[t] = 0;
      if (stall) begin
         for (int g = 0; g < r / 8; g++) begin
            stall_n[g*8 + int'($urandom_range(0, 7))] = 3;
            st_total += 3;
         end
      end
      dig   = compress(w, r, hp);
      s     = cyc + 1;
      e.dig = use_known ? known : dig;
      e.at  = s + r + 1 + st_total;
      if (sel == 0) q256.push_back(e);
      else          q512.push_back(e);
      drive(sel, 1'b1, junk_valid, {$urandom(), $urandom()}, hp);
      @(negedge clk);
      chk("start_busy", 512'(obs_busy(sel)), 512'd1);
      chk("start_ready", 512'(obs_ready(sel)), 512'd1);
      for (int t = 0; t < r; t++) begin
         for (int k = 0; k < stall_n[t]; k++) begin
            drive(sel, 1'b0, 1'b0, {$urandom(), $urandom()}, hp);
            @(negedge clk);
            chk("stall_busy", 512'(obs_busy(sel)), 512'd1);
            chk("stall_ready", 512'(obs_ready(sel)), 512'd1);
            chk("stall_done", 512'(obs_done(sel)), 512'd0);
         end
         if (t == ign_at) drive(sel, 1'b1, 1'b1, wk_cur[t], {$urandom(), $urandom(), 448'h0});
         else             drive(sel, 1'b0, 1'b1, wk_cur[t], hp);
         @(negedge clk);
      end
      drive(sel, 1'b0, 1'b0, {$urandom(), $urandom()}, hp);
      chk("final_ready", 512'(obs_ready(sel)), 512'd0);
      chk("final_busy", 512'(obs_busy(sel)), 512'd1);
      @(negedge clk);
      chk("done_cycle_busy", 512'(obs_busy(sel)), 512'd0);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      exp_t e;
      if (s_done === 1'b1) begin
         if (q256.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL sha256_spurious_done: got done at cycle %0d expected none", cyc);
         end else begin
            e = q256.pop_front();
            chk("sha256_digest", {256'h0, s_hout}, e.dig);
            chk("sha256_done_cycle", 512'(cyc), 512'(e.at));
         end
      end
      if (l_done === 1'b1) begin
         if (q512.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL sha512_spurious_done: got done at cycle %0d expected none", cyc);
         end else begin
            e = q512.pop_front();
            chk("sha512_digest", l_hout, e.dig);
            chk("sha512_done_cycle", 512'(cyc), 512'(e.at));
         end
      end
   end

   // ---------------- test sequence ----------------
   initial begin
      logic [511:0] d1, d2, hchain;
      reset = 1'b1;
      drive(0, 1'b0, 1'b0, 64'h0, 512'h0);
      drive(1, 1'b0, 1'b0, 64'h0, 512'h0);
      @(negedge clk);
      @(negedge clk);
      chk("rst_busy256", 512'(s_busy), 512'd0);
      chk("rst_ready256", 512'(s_ready), 512'd0);
      chk("rst_done256", 512'(s_done), 512'd0);
      chk("rst_hout256", 512'(s_hout), 512'd0);
      chk("rst_busy512", 512'(l_busy), 512'd0);
      chk("rst_ready512", 512'(l_ready), 512'd0);
      chk("rst_hout512", l_hout, 512'd0);
      reset = 1'b0;
      @(negedge clk);

      // SHA-256 "abc", with wk_valid high alongside start (must not be consumed)
      set_abc(32); sched(32, 64);
      run_block(0, IV256, 1'b0, 1'b1, -1, 1'b1, ABC256, d1);
      @(negedge clk);

      // SHA-512 "abc"
      set_abc(64); sched(64, 80);
      run_block(1, IV512, 1'b0, 1'b0, -1, 1'b1, ABC512, d1);
      @(negedge clk);

      // SHA-256 "abc" with 3-cycle stalls in every group of 8 rounds
      set_abc(32); sched(32, 64);
      run_block(0, IV256, 1'b1, 1'b0, -1, 1'b1, ABC256, d1);
      @(negedge clk);

      // Back-to-back two-block messages, second start in the done cycle
      set_rand(32); sched(32, 64);
      run_block(0, IV256, 1'b0, 1'b0, -1, 1'b0, 512'h0, d1);
      set_rand(32); sched(32, 64);
      run_block(0, d1, 1'b1, 1'b0, -1, 1'b0, 512'h0, d2);
      hchain = IV512;
      for (int b = 0; b < 3; b++) begin
         set_rand(64); sched(64, 80);
         run_block(1, hchain, (b == 1), 1'b0, -1, 1'b0, 512'h0, d1);
         hchain = d1;
      end
      @(negedge clk);

      // Reset after round 30 of a SHA-256 block; no done may follow
      set_abc(32); sched(32, 64);
      drive(0, 1'b1, 1'b0, 64'h0, IV256);
      @(negedge clk);
      for (int t = 0; t < 31; t++) begin
         drive(0, 1'b0, 1'b1, wk_cur[t], IV256);
         @(negedge clk);
      end
      reset = 1'b1;
      drive(0, 1'b0, 1'b0, 64'h0, IV256);
      #1;
      chk("midrst_busy", 512'(s_busy), 512'd0);
      chk("midrst_ready", 512'(s_ready), 512'd0);
      chk("midrst_done", 512'(s_done), 512'd0);
      chk("midrst_hout", 512'(s_hout), 512'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run_block(0, IV256, 1'b0, 1'b0, -1, 1'b1, ABC256, d1);
      @(negedge clk);

      // Start pulsed mid-block is ignored
      set_abc(64); sched(64, 80);
      run_block(1, IV512, 1'b0, 1'b0, 20, 1'b1, ABC512, d1);
      @(negedge clk);

      for (int k = 0; k < 300 && (q256.size() != 0 || q512.size() != 0); k++) @(negedge clk);
      chk("scoreboard_drained", 512'(q256.size() + q512.size()), 512'd0);
      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
